// File: rtl/cordic_rr_scheduler_if.sv
// cordic_rr_scheduler_if: requester-side and core-side signals of the CORDIC round-robin scheduler
interface cordic_rr_scheduler_if #(
    parameter int WIDTH = 31,
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]           req_valid;
    logic [N_REQ*(WIDTH+1)-1:0] req_x;
    logic [N_REQ*(WIDTH+1)-1:0] req_y;
    logic [N_REQ-1:0]           req_ready;
    logic [N_REQ-1:0]           resp_valid;
    logic signed [WIDTH:0]      resp_radius;
    logic signed [8:0]          resp_angle;
    logic                       resp_err;
    logic                       core_in_valid;
    logic signed [WIDTH:0]      core_x;
    logic signed [WIDTH:0]      core_y;
    logic                       core_out_valid;
    logic signed [WIDTH:0]      core_radius;
    logic signed [8:0]          core_angle;
    logic                       busy;
    logic [2:0]                 grant_id;

    modport slave (
        input  req_valid, req_x, req_y, core_out_valid, core_radius, core_angle,
        output req_ready, resp_valid, resp_radius, resp_angle, resp_err,
               core_in_valid, core_x, core_y, busy, grant_id
    );

    modport master (
        output req_valid, req_x, req_y, core_out_valid, core_radius, core_angle,
        input  req_ready, resp_valid, resp_radius, resp_angle, resp_err,
               core_in_valid, core_x, core_y, busy, grant_id
    );
endinterface

// File: rtl/cordic_rr_scheduler.sv
// cordic_rr_scheduler: round-robin sharing of one non-pipelined CORDIC vectoring core among N_REQ requesters
// Optional feature: define CORDIC_SCHED_TIMEOUT_EN to add a WAIT timeout that returns an error response.
module cordic_rr_scheduler #(
    parameter int WIDTH   = 31,
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input logic clk,
    input logic rst,
    cordic_rr_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                state, state_n;
    logic [2:0]            ptr, win;
    logic [2*N_REQ-1:0]    dbl;
    logic [N_REQ-1:0]      rot;
    int                    off;
    logic signed [WIDTH:0] x_sel, y_sel;
    logic                  timeout, accept, done;

`ifdef CORDIC_SCHED_TIMEOUT_EN
    logic [7:0] cnt;
    assign timeout = state == WAIT && cnt + 8'd1 == 8'(TIMEOUT - 1);
    // Count WAIT cycles; cleared while issuing so each job gets a fresh budget
    always_ff @(posedge clk) begin
        cnt <= (rst || state == ISSUE) ? '0 : (state == WAIT ? cnt + 8'd1 : cnt);
    end
`else
    assign timeout = 1'b0;
`endif

    assign accept = state == IDLE && |bus.req_valid;
    assign done   = state == WAIT && (bus.core_out_valid || timeout);

    // Rotate requests so ptr sits at bit 0, take the lowest set bit, then map back and select its operands
    always_comb begin
        dbl = {bus.req_valid, bus.req_valid} >> ptr;
        rot = dbl[N_REQ-1:0];
        off = 0;
        for (int k = N_REQ - 1; k >= 0; k--)
            if (rot[k]) off = k;
        win = 3'((int'(ptr) + off) % N_REQ);
        x_sel = '0;
        y_sel = '0;
        for (int i = 0; i < N_REQ; i++)
            if (win == 3'(i)) begin
                x_sel = bus.req_x[i*(WIDTH+1) +: WIDTH+1];
                y_sel = bus.req_y[i*(WIDTH+1) +: WIDTH+1];
            end
    end

    // Next-state logic; ISSUE and RESP each last exactly one cycle
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = accept ? ISSUE : IDLE;
            ISSUE:   state_n = WAIT;
            WAIT:    state_n = done ? RESP : WAIT;
            default: state_n = IDLE;
        endcase
    end

    // State and registered outputs; outputs are loaded one cycle ahead so they line up with the state they belong to
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            ptr             <= '0;
            bus.grant_id    <= '0;
            bus.req_ready   <= '0;
            bus.resp_valid  <= '0;
            bus.resp_radius <= '0;
            bus.resp_angle  <= '0;
            bus.resp_err    <= 1'b0;
            bus.core_in_valid <= 1'b0;
            bus.core_x      <= '0;
            bus.core_y      <= '0;
            bus.busy        <= 1'b0;
        end else begin
            state             <= state_n;
            bus.busy          <= state_n != IDLE;
            bus.core_in_valid <= accept;
            bus.core_x        <= accept ? x_sel : '0;
            bus.core_y        <= accept ? y_sel : '0;
            bus.req_ready     <= accept ? N_REQ'(1) << win : '0;
            bus.grant_id      <= accept ? win : bus.grant_id;
            bus.resp_valid    <= done ? N_REQ'(1) << bus.grant_id : '0;
            if (done) begin
                bus.resp_radius <= bus.core_out_valid ? bus.core_radius : '0;
                bus.resp_angle  <= bus.core_out_valid ? bus.core_angle : '0;
                bus.resp_err    <= !bus.core_out_valid;
            end
            if (state == RESP)
                ptr <= (int'(bus.grant_id) == N_REQ - 1) ? '0 : bus.grant_id + 3'd1;
        end
    end
endmodule

// File: doc/cordic_rr_scheduler.md
Name: cordic_rr_scheduler

Overview:
- Shares one non-pipelined CORDIC vectoring core (x,y -> radius, angle) among N_REQ requesters.
- Round-robin arbitration; one job in flight at a time.
- Sequences the core's single-cycle in_valid pulse, waits for out_valid, and routes the result back to the winning requester as a one-hot response pulse.
- Sits between the requesting engines and the core instance.

Parameters:
- WIDTH, 31, MSB index of signed x/y/radius buses (bus width WIDTH+1).
- N_REQ, 4, number of requesters, 2..8.
- TIMEOUT, 64, max cycles in WAIT before error response (optional feature only), 2..255.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- req_valid  in  N_REQ  per-requester request; held with data until accepted
- req_x  in  N_REQ*(WIDTH+1)  packed signed x, requester i at slice i
- req_y  in  N_REQ*(WIDTH+1)  packed signed y
- req_ready  out  N_REQ  one-hot acceptance pulse
- resp_valid  out  N_REQ  one-hot result pulse
- resp_radius  out  WIDTH+1  signed result radius
- resp_angle  out  9  signed result angle, degrees
- resp_err  out  1  result invalid (timeout)
- core_in_valid  out  1  single-cycle start to core
- core_x  out  WIDTH+1  x to core
- core_y  out  WIDTH+1  y to core
- core_out_valid  in  1  core result strobe
- core_radius  in  WIDTH+1  core radius
- core_angle  in  9  core angle
- busy  out  1  high in any state except IDLE
- grant_id  out  3  index of current or last granted requester

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: all outputs 0, state IDLE, rr pointer ptr=0, internal x/y/result registers 0. Reset mid-operation aborts the job with no resp_valid.
- The core keeps its own active-low reset; the integrator drives it from ~rst.
- FSM states IDLE, ISSUE, WAIT, RESP; all outputs registered.
- IDLE, when |req_valid:
  - winner = first set bit of req_valid searching ptr, ptr+1, ... mod N_REQ.
  - Latch that requester's x/y; grant_id<=winner; req_ready[winner]<=1; go to ISSUE.
  - With no request: stay in IDLE.
- ISSUE (exactly 1 cycle):
  - req_ready[grant_id]=1, completing the handshake at this cycle's end; the requester may drop or change req_valid/data afterwards.
  - core_in_valid=1, core_x/core_y=latched values.
  - Next state WAIT; wait counter cleared.
- WAIT:
  - core_in_valid=0, core_x/core_y=0.
  - req_valid of all ports ignored (no second grant).
  - On core_out_valid=1: capture core_radius/core_angle and go to RESP.
- RESP (1 cycle):
  - resp_valid[grant_id]=1, resp_radius/resp_angle=captured values, resp_err per optional feature.
  - ptr<=(grant_id+1) mod N_REQ; next state IDLE.
  - No backpressure on responses.
- Outside ISSUE: req_ready=0 and core_in_valid=0. Outside RESP: resp_valid=0. resp_radius/resp_angle/resp_err hold their last values.
- core_out_valid outside WAIT, including the same cycle as ISSUE, is ignored.
- Latency: a request accepted from IDLE at cycle t gets core_in_valid at t+1. With core latency L (out_valid L cycles after in_valid), resp_valid occurs at t+L+2.
- Back-to-back: a new arbitration is possible in the cycle after RESP, giving a minimum 3-cycle overhead per job.
- Fairness: with all ports requesting continuously, the grant order is 0,1,...,N_REQ-1,0,... Each port waits at most N_REQ-1 jobs.
- No arithmetic on data; values pass through unmodified, sign preserved.

Optional Feature:
- Macro CORDIC_SCHED_TIMEOUT_EN.
- Defined:
  - 8-bit wait counter increments each WAIT cycle.
  - If it reaches TIMEOUT-1 with core_out_valid=0, the block goes to RESP with resp_err=1, resp_radius=0 and resp_angle=0.
  - core_out_valid in that same cycle wins: normal result, resp_err=0.
  - A late core_out_valid after a timeout is ignored unless the FSM is again in WAIT.
- Undefined: no counter; WAIT lasts indefinitely; resp_err is constant 0.

Test Plan:
- Reset: rst=1 for 3 cycles with random req_valid -> all outputs 0, busy=0, grant_id=0. After release with no requests -> state stays IDLE.
- Single job: port 2 sends x=3000, y=4000; core model L=20 returns 5000/53.
  - core_in_valid one cycle with core_x=3000, core_y=4000.
  - req_ready=4'b0100 in the same cycle.
  - resp_valid=4'b0100 with radius 5000, angle 53 at accept+22.
- Fairness: all 4 req_valid held high from reset -> grant_id sequence 0,1,2,3,0,1; no port served twice before others.
- Pointer: ports 1 and 3 request with ptr=2 -> port 3 is served first, then port 1.
- Abort: rst pulsed during WAIT, then core_out_valid arrives 5 cycles later -> no resp_valid, busy=0, ptr=0. The next request proceeds normally.
- Timeout (macro defined, TIMEOUT=64): core never responds -> resp_valid for the granted port with resp_err=1 and radius/angle 0, 64 cycles after ISSUE. Without the macro -> busy stays 1 for 500 cycles.
